// File: rtl/mem_byte_initiator.sv
// rtl/mem_byte_initiator.sv - splits word/half/byte load-store requests into single-byte memory accesses
module mem_byte_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic                  o_mem_write,
    output logic                  o_mem_request,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_data_DV
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {QUIET, IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic [1:0]            quiet_cnt;
    logic [TW-1:0]         tcnt;
    logic [1:0]            k;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf;

    logic [31:0]           assembled;
    logic [31:0]           load_value;
    logic [1:0]            last_k;
    logic [1:0]            next_k;
    logic [ADDR_WIDTH-1:0] next_addr;

    always_comb begin
        assembled = rbuf;
        assembled[k*DATA_WIDTH +: DATA_WIDTH] = i_mem_data;
        case (size_q)
            2'b00:   load_value = {{24{~uns_q & assembled[7]}}, assembled[7:0]};
            2'b01:   load_value = {{16{~uns_q & assembled[15]}}, assembled[15:0]};
            default: load_value = assembled;
        endcase
        case (size_q)
            2'b00:   last_k = 2'd0;
            2'b01:   last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
        next_k    = k + 2'd1;
        // Address arithmetic wraps naturally at the memory size.
        next_addr = base_q + {{(ADDR_WIDTH-2){1'b0}}, next_k};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= QUIET;
            quiet_cnt     <= 2'd0;
            tcnt          <= '0;
            k             <= 2'd0;
            we_q          <= 1'b0;
            size_q        <= 2'd0;
            uns_q         <= 1'b0;
            base_q        <= '0;
            wdata_q       <= '0;
            rbuf          <= '0;
            o_rdata       <= '0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_busy        <= 1'b1;
            o_mem_data    <= '0;
            o_mem_address <= '0;
            o_mem_write   <= 1'b0;
            o_mem_request <= 1'b0;
        end else begin
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_mem_request <= 1'b0;
            o_mem_write   <= 1'b0;
            case (state)
                QUIET: begin
                    // Let any access issued before reset finish before starting new ones.
                    if (quiet_cnt == 2'd3) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        quiet_cnt <= quiet_cnt + 2'd1;
                    end
                end
                IDLE: begin
                    if (i_req) begin
                        we_q          <= i_we;
                        size_q        <= i_size;
                        uns_q         <= i_unsigned;
                        base_q        <= i_addr;
                        wdata_q       <= i_wdata;
                        k             <= 2'd0;
                        state         <= ISSUE;
                        o_busy        <= 1'b1;
                        o_mem_request <= 1'b1;
                        o_mem_write   <= i_we;
                        o_mem_address <= i_addr;
                        o_mem_data    <= i_wdata[DATA_WIDTH-1:0];
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    tcnt  <= '0;
                end
                WAIT: begin
                    if (i_mem_data_DV) begin
                        rbuf <= assembled;
                        if (k == last_k) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            if (!we_q) begin
                                o_rdata <= load_value;
                            end
                        end else begin
                            k             <= next_k;
                            state         <= ISSUE;
                            o_mem_request <= 1'b1;
                            o_mem_write   <= we_q;
                            o_mem_address <= next_addr;
                            o_mem_data    <= wdata_q[next_k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end else if (tcnt == TW'(TIMEOUT)) begin
                        state   <= DONE;
                        o_done  <= 1'b1;
                        o_error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= QUIET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_initiator.sv
// tb/tb_mem_byte_initiator.sv - scoreboard bench for mem_byte_initiator with a 4-cycle byte memory model
module tb_mem_byte_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done, error, busy;
    logic [7:0]  mem_data_out;
    logic [12:0] mem_address;
    logic        mem_write, mem_request;
    logic [7:0]  mem_rd = '0;
    logic        mem_dv = 1'b0;

    logic        dv_en = 1'b1;
    logic        pl_we = 1'b0;
    logic [12:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    logic [7:0]  mem [0:8191];
    logic [2:0]  mcnt = '0;
    logic [12:0] maddr = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { logic [31:0] rd; logic err; int dcyc; } done_t;
    typedef struct { logic [12:0] a; logic wr; logic [7:0] d; } mreq_t;
    done_t dq[$];
    mreq_t mq[$];
    done_t de;
    mreq_t me;

    mem_byte_initiator dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata),
        .o_done(done), .o_error(error), .o_busy(busy), .o_mem_data(mem_data_out),
        .o_mem_address(mem_address), .o_mem_write(mem_write), .o_mem_request(mem_request),
        .i_mem_data(mem_rd), .i_mem_data_DV(mem_dv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: request sampled at edge t, data-valid visible in cycle t+4.
    always @(posedge clk) begin
        mem_dv <= 1'b0;
        if (pl_we) mem[pl_addr] <= pl_data;
        if (mcnt != 3'd0) begin
            mcnt <= mcnt - 3'd1;
            if (mcnt == 3'd1) begin
                mem_dv <= dv_en;
                mem_rd <= mem[maddr];
            end
        end else if (mem_request) begin
            maddr <= mem_address;
            mcnt  <= 3'd3;
            if (mem_write) mem[mem_address] <= mem_data_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mem_request) begin
            if (mq.size() == 0) begin
                chk("unexpected_mem_request", {31'd0, mem_request}, 32'd0);
            end else begin
                me = mq.pop_front();
                chk("mem_address", {19'd0, mem_address}, {19'd0, me.a});
                chk("mem_write", {31'd0, mem_write}, {31'd0, me.wr});
                if (me.wr) chk("mem_wdata", {24'd0, mem_data_out}, {24'd0, me.d});
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                de = dq.pop_front();
                chk("rdata", rdata, de.rd);
                chk("error", {31'd0, error}, {31'd0, de.err});
                chk("done_cycle", cyc, de.dcyc);
            end
        end else if (error) begin
            chk("error_without_done", {31'd0, error}, 32'd0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait_expired", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [12:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int nreq, input bit push_done, output int c);
        wait_idle();
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        c = cyc;
        if (push_done) dq.push_back('{exp_rd, exp_err, exp_err ? c + 18 : c + 1 + 5 * nreq});
        for (int i = 0; i < nreq; i++) begin
            mq.push_back('{a + 13'(i), w, 8'((wd >> (8 * i)) & 32'hFF)});
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    logic [12:0] pl_a_tab [6] = '{13'h100, 13'h101, 13'h102, 13'h103, 13'h005, 13'h040};
    logic [7:0]  pl_d_tab [6] = '{8'h11, 8'h22, 8'h33, 8'h84, 8'h80, 8'h5A};

    initial begin
        int c;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = pl_a_tab[i]; pl_data = pl_d_tab[i];
        end
        @(negedge clk);
        pl_we = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_mem_request", {31'd0, mem_request}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", {19'd0, mem_address}, 32'd0);
        chk("rst_mem_data", {24'd0, mem_data_out}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("quiet_busy", {31'd0, busy}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) @(negedge clk);
        end

        do_req(1'b0, 2'b10, 1'b0, 13'h100, 32'h0, 32'h84332211, 1'b0, 4, 1'b1, c);
        do_req(1'b0, 2'b00, 1'b0, 13'h005, 32'h0, 32'hFFFFFF80, 1'b0, 1, 1'b1, c);
        do_req(1'b0, 2'b00, 1'b1, 13'h005, 32'h0, 32'h00000080, 1'b0, 1, 1'b1, c);
        do_req(1'b1, 2'b01, 1'b0, 13'h1FFF, 32'h0000BEEF, 32'h00000080, 1'b0, 2, 1'b1, c);
        wait_idle();
        chk("mem_1fff", {24'd0, mem[13'h1FFF]}, 32'hEF);
        chk("mem_0000", {24'd0, mem[13'h0000]}, 32'hBE);
        do_req(1'b0, 2'b01, 1'b0, 13'h1FFF, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b1, c);
        do_req(1'b0, 2'b01, 1'b1, 13'h1FFF, 32'h0, 32'h0000BEEF, 1'b0, 2, 1'b1, c);

        do_req(1'b0, 2'b11, 1'b0, 13'h100, 32'h0, 32'h84332211, 1'b0, 4, 1'b1, c);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b00; addr = 13'h020;
        @(negedge clk);
        req = 1'b0;

        wait_idle();
        dv_en = 1'b0;
        do_req(1'b0, 2'b00, 1'b0, 13'h005, 32'h0, 32'h84332211, 1'b1, 1, 1'b1, c);
        wait_idle();
        dv_en = 1'b1;
        do_req(1'b0, 2'b00, 1'b1, 13'h005, 32'h0, 32'h00000080, 1'b0, 1, 1'b1, c);

        do_req(1'b0, 2'b10, 1'b0, 13'h100, 32'h0, 32'h0, 1'b0, 3, 1'b0, c);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("reset_quiet_busy", {31'd0, busy}, (i < 4) ? 32'd1 : 32'd0);
            chk("reset_quiet_request", {31'd0, mem_request}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        chk("rdata_after_reset", rdata, 32'd0);
        do_req(1'b0, 2'b00, 1'b0, 13'h101, 32'h0, 32'h00000022, 1'b0, 1, 1'b1, c);
        do_req(1'b0, 2'b00, 1'b0, 13'h103, 32'h0, 32'hFFFFFF84, 1'b0, 1, 1'b1, c);

        wait_idle();
        repeat (5) @(negedge clk);
        chk("done_queue_drained", dq.size(), 32'd0);
        chk("mem_queue_drained", mq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_byte_initiator.md
# mem_byte_initiator

Word-level initiator for the 8 KB byte-wide boot/cache memory. It accepts byte, half-word and word load/store requests from the core's load/store unit and turns each one into a sequence of single-byte memory requests. It waits for the memory's data-valid pulse after every byte, assembles little-endian read data with sign or zero extension, and signals completion with a one-cycle pulse. It sits between the load/store unit and the memory, driving the memory's data, address, write and request inputs.

## Interface
- DATA_WIDTH, 8: memory word width (bits); fixed byte lane size.
- ADDR_WIDTH, 13: memory address width; byte addresses wrap modulo 2^ADDR_WIDTH.
- TIMEOUT, 15: maximum cycles from a byte request to its data-valid before abort.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  1  core request strobe; sampled only when o_busy=0.
- i_we  in  1  1=store, 0=load; sampled with i_req.
- i_size  in  2  00=byte, 01=half, 10/11=word.
- i_unsigned  in  1  1=zero-extend loads, 0=sign-extend.
- i_addr  in  ADDR_WIDTH  base byte address.
- i_wdata  in  32  store data; byte k = i_wdata[8k+7:8k].
- o_rdata  out  32  assembled load data; updated only on load completion.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  one-cycle pulse, coincident with o_done, on timeout abort.
- o_busy  out  1  high while a transaction or the post-reset quiet period is active.
- o_mem_data  out  DATA_WIDTH  byte to be written.
- o_mem_address  out  ADDR_WIDTH  byte address.
- o_mem_write  out  1  write qualifier, driven with o_mem_request.
- o_mem_request  out  1  one-cycle byte request.
- i_mem_data  in  DATA_WIDTH  memory read byte.
- i_mem_data_DV  in  1  memory data-valid pulse.

## Operation
- Memory contract:
  - A request sampled at an edge is answered by a data-valid pulse 4 cycles later (request in cycle t, data-valid in cycle t+4).
  - Requests are ignored while the memory is busy.
  - A write commits at the sampling edge.
  - Address and data must stay stable from request until data-valid.
- Byte count N: 1, 2 or 4 from i_size. Byte k goes to address (i_addr+k) mod 2^ADDR_WIDTH.
- State machine:
  - QUIET: entered on reset. Counts 4 cycles with o_busy=1, then goes to IDLE. This drains any memory access still in flight.
  - IDLE: o_busy=0. On i_req=1, latch we/size/unsigned/addr/wdata, set k=0, go to ISSUE.
  - ISSUE: drive o_mem_request=1 (o_mem_write=we) for exactly one cycle, then go to WAIT. Clear the timeout counter.
  - WAIT: hold o_mem_address and o_mem_data.
    - On i_mem_data_DV: capture i_mem_data into lane k (loads). If k=N-1, go to DONE; else k+1 and go to ISSUE.
    - If the timeout counter reaches TIMEOUT: set the error flag and go to DONE.
  - DONE: o_done=1 (and o_error if flagged) for one cycle, then go to IDLE.
- Read data:
  - o_rdata is written on entry to DONE for successful loads.
  - Byte loads: bits [31:8] are extended from bit 7.
  - Half-word loads: bits [31:16] are extended from bit 15.
  - Extension is zero when i_unsigned=1, otherwise sign.
  - Stores and aborted loads leave o_rdata unchanged.
- i_mem_data_DV outside WAIT is ignored.
- i_req while o_busy=1 is ignored; it is not queued.
- Reset values: o_mem_request=0, o_mem_write=0, o_mem_address=0, o_mem_data=0, o_rdata=0, o_done=0, o_error=0, o_busy=1.

## Timing
- All outputs are registered.
- Let the i_req sampling edge end cycle c:
  - ISSUE occupies cycle c+1.
  - Byte k's data-valid arrives in cycle c+5+5k.
  - o_done is high in cycle c+1+5N: byte c+6, half c+11, word c+21.
- o_busy rises in cycle c+1 and falls in the cycle after o_done, so the next request can be sampled at the end of cycle c+2+5N.
- Timeout abort: o_done and o_error are high TIMEOUT+2 cycles after the unanswered ISSUE cycle.
- Reset asserted mid-transaction: the next cycle shows o_mem_request=0 and o_done=0, and the block enters QUIET. No partial o_rdata update occurs. Memory writes already committed stay committed.

## Test plan
- Word load: memory holds 0x11,0x22,0x33,0x84 at 0x100..0x103; i_size=10 -> o_rdata=0x84332211, o_done exactly 20 cycles after ISSUE start, 4 request pulses at 0x100..0x103.
- Signed and unsigned byte load: 0x80 at 0x005; i_unsigned=0 -> 0xFFFFFF80; i_unsigned=1 -> 0x00000080.
- Half-word store then load with wrap-around: store 0xBEEF at 0x1FFF -> 0xEF written to 0x1FFF and 0xBE to 0x0000; signed half load from 0x1FFF -> 0xFFFFBEEF; o_rdata unchanged after the store.
- Busy rejection: pulse i_req with addr 0x020 two cycles after a word load starts -> ignored; exactly 4 memory requests and one o_done.
- Timeout: data-valid held low -> o_done and o_error pulse together 17 cycles after ISSUE; o_rdata unchanged; the next load succeeds.
- Reset in WAIT of byte 2 of a word load -> o_mem_request stays 0 for the 4 QUIET cycles, o_busy=1 for those cycles; a late data-valid is ignored; a subsequent byte load returns correct data.
